// File: rtl/hopfield_core.sv
// hopfield_core: Hopfield associative memory with a serial datapath.
// The core visits one weight per clock for clear, Hebbian learn and recall.
// Recall is asynchronous: each neuron's new value is visible to the neurons
// that follow it in the same sweep.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for clear / learn / recall request (ready high)
// CLEAR  | zero one weight per cycle, N*N cycles
// LEARN  | Hebbian update of one weight per cycle, N*N cycles
// UPDATE | accumulate one term per cycle; decide neuron k at m = N-1
// CHECK  | count the sweep; decide converged / iteration limit / again
// DONE   | one-cycle done pulse
module hopfield_core #(
    parameter int N       = 25,
    parameter int WW      = 4,
    parameter int SW      = 8,
    parameter int MAXITER = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         learn_valid,
    output logic                         learn_ready,
    input  logic [N-1:0]                 learn_pattern,
    input  logic                         recall_valid,
    output logic                         recall_ready,
    input  logic [N-1:0]                 recall_pattern,
    output logic [N-1:0]                 state_out,
    output logic                         busy,
    output logic                         done,
    output logic                         converged,
    output logic [$clog2(MAXITER+1)-1:0] iter_count
);

    localparam int IW = $clog2(MAXITER + 1);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST     = KW'(N - 1);
    localparam logic [IW-1:0] ITER_MAX = IW'(MAXITER);

    localparam logic signed [WW-1:0] WMAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] WMIN = -WMAX;
    localparam logic signed [WW-1:0] WONE = {{(WW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] AMAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0] AMIN = {1'b1, {(SW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEARN,
        UPDATE,
        CHECK,
        DONE
    } state_t;

    state_t state, state_n;

    logic [KW-1:0]          k, m;
    logic [N-1:0]           lpat;
    logic                   changed;
    logic                   last;
    logic [IW-1:0]          iter_next;

    logic signed [WW-1:0]   w [N][N];
    logic signed [WW-1:0]   wsel;
    logic signed [WW-1:0]   wlearn;
    logic signed [SW-1:0]   wext;
    logic signed [SW-1:0]   term;
    logic signed [SW-1:0]   acc;
    logic signed [SW-1:0]   acc_next;
    logic        [SW:0]     sum_wide;
    logic                   pos, neg;

    assign last      = (k == LAST) && (m == LAST);
    assign iter_next = iter_count + 1'b1;

    // Weight read, saturating Hebbian step and saturating accumulate.
    always_comb begin
        wsel   = w[k][m];
        wlearn = wsel;
        if (lpat[k] == lpat[m]) begin
            if (wsel != WMAX) wlearn = wsel + WONE;
        end else begin
            if (wsel != WMIN) wlearn = wsel - WONE;
        end

        wext     = {{(SW-WW){wsel[WW-1]}}, wsel};
        term     = state_out[m] ? wext : -wext;
        sum_wide = {acc[SW-1], acc} + {term[SW-1], term};
        if (sum_wide[SW] != sum_wide[SW-1])
            acc_next = sum_wide[SW] ? AMIN : AMAX;
        else
            acc_next = sum_wide[SW-1:0];

        pos = !acc_next[SW-1] && (acc_next != '0);
        neg = acc_next[SW-1];
    end

    // State register; reset always restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst) state <= CLEAR;
        else      state <= state_n;
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_n      = state;
        busy         = (state != IDLE);
        learn_ready  = rst && (state == IDLE);
        recall_ready = rst && (state == IDLE);
        done         = rst && (state == DONE);
        case (state)
            IDLE: begin
                if (clear)             state_n = CLEAR;
                else if (learn_valid)  state_n = LEARN;
                else if (recall_valid) state_n = UPDATE;
            end
            CLEAR:  if (last) state_n = IDLE;
            LEARN:  if (last) state_n = IDLE;
            UPDATE: if (last) state_n = CHECK;
            CHECK: begin
                if (!changed || (iter_next == ITER_MAX)) state_n = DONE;
                else                                     state_n = UPDATE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Weight store: cleared or Hebbian-updated one entry per cycle; diagonal untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR)
                w[k][m] <= '0;
            else if ((state == LEARN) && (k != m))
                w[k][m] <= wlearn;
        end
    end

    // Sweep counters, neuron state, accumulator and recall status.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k          <= '0;
            m          <= '0;
            lpat       <= '0;
            acc        <= '0;
            changed    <= 1'b0;
            state_out  <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    k   <= '0;
                    m   <= '0;
                    acc <= '0;
                    if (clear) begin
                        // clear wins; nothing else latched
                    end else if (learn_valid) begin
                        lpat <= learn_pattern;
                    end else if (recall_valid) begin
                        state_out  <= recall_pattern;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        changed    <= 1'b0;
                    end
                end
                CLEAR, LEARN: begin
                    if (m == LAST) begin
                        m <= '0;
                        k <= (k == LAST) ? '0 : k + 1'b1;
                    end else begin
                        m <= m + 1'b1;
                    end
                end
                UPDATE: begin
                    if (m == LAST) begin
                        m   <= '0;
                        k   <= (k == LAST) ? '0 : k + 1'b1;
                        acc <= '0;
                        if (pos) state_out[k] <= 1'b1;
                        else if (neg) state_out[k] <= 1'b0;
                        if ((pos && !state_out[k]) || (neg && state_out[k]))
                            changed <= 1'b1;
                    end else begin
                        m   <= m + 1'b1;
                        acc <= acc_next;
                    end
                end
                CHECK: begin
                    iter_count <= iter_next;
                    converged  <= !changed;
                    if (state_n == UPDATE) changed <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/hopfield_core.md
HOPFIELD_CORE -- requirements
Module: hopfield_core

Interface
REQ-001 The module SHALL have parameter N, default 25, giving the neuron count and pattern width.
REQ-002 The module SHALL have parameter WW, default 4, giving the signed weight width.
REQ-003 The module SHALL have parameter SW, default 8, giving the signed accumulator width.
REQ-004 The module SHALL have parameter MAXITER, default 16, giving the maximum number of recall sweeps.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 clear  input  1  request to zero all weights.
REQ-008 learn_valid / learn_ready  input / output  1 / 1  pattern-store handshake.
REQ-009 learn_pattern  input  N  pattern to store; bit i is neuron i.
REQ-010 recall_valid / recall_ready  input / output  1 / 1  recall-start handshake.
REQ-011 recall_pattern  input  N  initial neuron state for recall.
REQ-012 state_out  output  N  current neuron state register.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at the end of a recall.
REQ-015 converged  output  1  high when the last recall ended on a sweep with no neuron change.
REQ-016 iter_count  output  clog2(MAXITER+1)  number of sweeps run by the last recall.

Function
REQ-017 The module SHALL implement FSM states IDLE, CLEAR, LEARN, UPDATE, CHECK and DONE.
REQ-018 The module SHALL hold an N*N signed WW-bit weight store w[k][m], with index k*N+m.
REQ-019 learn_ready and recall_ready SHALL be high only in IDLE.
REQ-020 In IDLE, when several requests are present in one cycle, priority SHALL be clear > learn_valid > recall_valid; the losing requests are not accepted and keep waiting.
REQ-021 CLEAR SHALL write 0 to one weight per cycle (N*N cycles) and then go to IDLE.
REQ-022 LEARN SHALL latch learn_pattern p on accept.
REQ-023 LEARN SHALL then visit one weight per cycle (N*N cycles), doing w[k][m] += (p[k]==p[m]) ? +1 : -1 for k != m.
REQ-024 Learn updates SHALL saturate at +(2^(WW-1)-1) and -(2^(WW-1)-1).
REQ-025 Diagonal weights w[k][k] SHALL stay 0.
REQ-026 After LEARN the FSM SHALL return to IDLE.
REQ-027 Recall accept SHALL load state_out from recall_pattern, clear iter_count and converged, and enter UPDATE.
REQ-028 UPDATE SHALL process neurons k = 0..N-1 in order, adding one term per cycle: s[m] ? w[k][m] : -w[k][m].
REQ-029 The accumulator SHALL saturate at the SW-bit signed limits.
REQ-030 After term m = N-1, the same cycle SHALL set s[k] to 1 if sum > 0, to 0 if sum < 0, and leave it unchanged if sum == 0.
REQ-031 Updates SHALL be asynchronous: later neurons in a sweep see earlier updated bits.
REQ-032 Any bit flip during a sweep SHALL set a per-sweep changed flag; each sweep lasts N*N cycles.
REQ-033 CHECK (1 cycle) SHALL increment iter_count.
REQ-034 From CHECK, the FSM SHALL go to DONE with converged=1 if changed==0.
REQ-035 From CHECK, the FSM SHALL go to DONE with converged=0 if iter_count reaches MAXITER.
REQ-036 Otherwise, from CHECK the FSM SHALL clear changed and start another sweep.
REQ-037 DONE SHALL assert done for exactly 1 cycle, then go to IDLE.
REQ-038 state_out, converged and iter_count SHALL hold their values until the next recall accept.
REQ-039 Inputs other than rst SHALL be ignored while busy; there is no abort except reset.

Reset
REQ-040 While rst==0, the module SHALL set state_out=0, iter_count=0, converged=0, done=0, learn_ready=0 and recall_ready=0.
REQ-041 On release of reset, the FSM SHALL enter CLEAR, so weights are all zero after N*N cycles and before any learn_ready or recall_ready.
REQ-042 Reset asserted mid-LEARN, mid-UPDATE or mid-CLEAR SHALL abort the operation in the same cycle and restart the CLEAR sequence of REQ-041.

Verification
REQ-043 Release rst -> busy=1 for exactly 625 cycles (N=25), then learn_ready=1 and recall_ready=1.
REQ-044 With no patterns learned, recall 25'h0E94A4F -> all sums 0, state_out=25'h0E94A4F, converged=1, iter_count=1.
REQ-045 Learn 25'h0E94A4F, then recall the same pattern -> state_out=25'h0E94A4F, converged=1, iter_count=1, done pulse 627 cycles after accept.
REQ-046 Learn 25'h0E94A4F, then recall with bit 0 flipped (25'h0E94A4E) -> state_out=25'h0E94A4F, converged=1, iter_count=2.
REQ-047 Learn the same pattern 10 times with WW=4 -> no wrap: recall of the pattern with bit 3 flipped still restores it, converged=1.
REQ-048 clear, learn_valid and recall_valid all high in one IDLE cycle -> CLEAR runs (625 busy cycles) and learn is accepted next; separately, with MAXITER=1 and a flipped-bit recall -> done with converged=0, iter_count=1.
